// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative 32-bit multiply/divide unit for a MIPS-style pipeline.
// Divides use a 32-step restoring algorithm on operand magnitudes, with the
// signs fixed up on the final step. Multiplies hold for MUL_CYCLES cycles.
// Results land in hi_out/lo_out and are announced by a one-cycle write pulse.
module muldiv_unit #(
    parameter int MUL_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        cancel,
    output logic        stallreq,
    output logic        hi_we,
    output logic        lo_we,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    typedef enum logic [1:0] {IDLE, DIV_RUN, MUL_RUN, DONE} state_t;

    localparam logic [5:0] DIV_LAST = 6'd31;
    localparam logic [5:0] MUL_LAST = 6'(MUL_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic        accept;
    logic        div_by_zero;
    logic [5:0]  iter;
    logic [1:0]  op_r;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvs;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [32:0] shifted;
    logic [32:0] diff;
    logic [31:0] step_q;
    logic [31:0] step_r;
    logic [31:0] q_fin;
    logic [31:0] r_fin;
    logic        mul_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] product;

    // Operand magnitudes for the divider; only signed DIV (op 00) takes abs.
    assign abs_a       = (!op[0] && src_a[31]) ? (~src_a + 32'd1) : src_a;
    assign abs_b       = (!op[0] && src_b[31]) ? (~src_b + 32'd1) : src_b;
    assign div_by_zero = !op[1] && (src_b == 32'd0);

    // One restoring step: shift the next dividend bit into the partial
    // remainder and keep the subtraction only if it did not go negative.
    always_comb begin
        shifted = {rem, quo[31]};
        diff    = shifted - {1'b0, dvs};
        step_r  = diff[32] ? shifted[31:0] : diff[31:0];
        step_q  = {quo[30:0], ~diff[32]};
        q_fin   = neg_q ? (~step_q + 32'd1) : step_q;
        r_fin   = neg_r ? (~step_r + 32'd1) : step_r;
    end

    // Full 64-bit product; sign- or zero-extending to 64 bits lets one
    // truncated multiplier serve both MULT and MULTU.
    always_comb begin
        mul_signed = (op_r == 2'b10);
        mul_a      = mul_signed ? {{32{a_r[31]}}, a_r} : {32'd0, a_r};
        mul_b      = mul_signed ? {{32{b_r[31]}}, b_r} : {32'd0, b_r};
        product    = mul_a * mul_b;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs; reset and cancel silence everything.
    always_comb begin
        state_next = state;
        stallreq   = 1'b0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;
        accept     = 1'b0;
        if (rst) begin
            state_next = IDLE;
        end else if (cancel) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        accept   = 1'b1;
                        stallreq = 1'b1;
                        if (div_by_zero) begin
                            state_next = DONE;
                        end else if (op[1]) begin
                            state_next = MUL_RUN;
                        end else begin
                            state_next = DIV_RUN;
                        end
                    end
                end
                DIV_RUN: begin
                    stallreq = 1'b1;
                    if (iter == DIV_LAST) begin
                        state_next = DONE;
                    end
                end
                MUL_RUN: begin
                    stallreq = 1'b1;
                    if (iter == MUL_LAST) begin
                        state_next = DONE;
                    end
                end
                DONE: begin
                    hi_we      = 1'b1;
                    lo_we      = 1'b1;
                    state_next = IDLE;
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // Datapath: latch operands on accept, iterate, and commit the result on
    // the step that leads into DONE so it is stable during the write pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            iter   <= 6'd0;
            op_r   <= 2'd0;
            a_r    <= 32'd0;
            b_r    <= 32'd0;
            quo    <= 32'd0;
            rem    <= 32'd0;
            dvs    <= 32'd0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            hi_out <= 32'd0;
            lo_out <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_r  <= op;
                        a_r   <= src_a;
                        b_r   <= src_b;
                        iter  <= 6'd0;
                        quo   <= abs_a;
                        rem   <= 32'd0;
                        dvs   <= abs_b;
                        neg_q <= !op[0] && (src_a[31] ^ src_b[31]);
                        neg_r <= !op[0] && src_a[31];
                        if (div_by_zero) begin
                            lo_out <= 32'hFFFF_FFFF;
                            hi_out <= src_a;
                        end
                    end
                end
                DIV_RUN: begin
                    if (!cancel) begin
                        quo  <= step_q;
                        rem  <= step_r;
                        iter <= iter + 6'd1;
                        if (iter == DIV_LAST) begin
                            lo_out <= q_fin;
                            hi_out <= r_fin;
                        end
                    end
                end
                MUL_RUN: begin
                    if (!cancel) begin
                        iter <= iter + 6'd1;
                        if (iter == MUL_LAST) begin
                            hi_out <= product[63:32];
                            lo_out <= product[31:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit. Every operation expected
// to complete pushes its modelled {hi,lo} result; a monitor pops and compares
// on each write pulse. Scenario tasks add latency and literal result checks.
module tb_muldiv_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        cancel;
    logic        stallreq;
    logic        hi_we;
    logic        lo_we;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int          total;
    int          bad;
    logic [63:0] exp_q[$];

    muldiv_unit #(.MUL_CYCLES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .cancel   (cancel),
        .stallreq (stallreq),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .hi_out   (hi_out),
        .lo_out   (lo_out)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case a scenario wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: {hi, lo} for one operation, built from language
    // arithmetic rather than a shift-subtract loop.
    function automatic logic [63:0] model(input logic [1:0] m_op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint    sp;
        logic [63:0] up;
        int        sa;
        int        sb;
        int        q;
        int        r;
        if (m_op == 2'b10) begin
            sp = longint'($signed(a)) * longint'($signed(b));
            return sp;
        end else if (m_op == 2'b11) begin
            up = {32'd0, a} * {32'd0, b};
            return up;
        end else if (b == 32'd0) begin
            return {a, 32'hFFFF_FFFF};
        end else if (m_op == 2'b01) begin
            return {a % b, a / b};
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            return {32'd0, 32'h8000_0000};
        end else begin
            sa = a;
            sb = b;
            q  = sa / sb;
            r  = sa % sb;
            return {r, q};
        end
    endfunction

    function automatic int latency(input logic [1:0] m_op, input logic [31:0] b);
        if (m_op[1]) return 3;
        if (b == 32'd0) return 1;
        return 33;
    endfunction

    // Scoreboard monitor: each write pulse must match the oldest expectation.
    always @(negedge clk) begin
        logic [63:0] e;
        if (hi_we === 1'b1 || lo_we === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL sb_unexpected_write: got hi=%h lo=%h, required no write",
                         hi_out, lo_out);
            end else begin
                e = exp_q.pop_front();
                if ({hi_out, lo_out} !== e || hi_we !== 1'b1 || lo_we !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL sb_result: got hi=%h lo=%h we=%b%b, required hi=%h lo=%h we=11",
                             hi_out, lo_out, hi_we, lo_we, e[63:32], e[31:0]);
                end
            end
        end
    end

    // Drive one request at a falling edge; push its expectation if it is
    // supposed to complete.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit expect_done);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        if (expect_done) exp_q.push_back(model(o, a, b));
    endtask

    // Drop start after the accepting edge and wait (bounded) for the write
    // pulse. cycles counts falling edges after acceptance; -1 on timeout.
    task automatic wait_done(output int cycles, output int stall_low);
        cycles    = -1;
        stall_low = 0;
        @(posedge clk);
        #1 start = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (hi_we === 1'b1) begin
                cycles = n;
                break;
            end
            if (stallreq !== 1'b1) stall_low++;
        end
    endtask

    task automatic test_reset;
        rst    = 1'b1;
        start  = 1'b1;
        op     = 2'b01;
        src_a  = 32'h55;
        src_b  = 32'd0;
        cancel = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (stallreq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_stall: got %b, required 0", stallreq);
        end
        total++;
        if (hi_we !== 1'b0 || lo_we !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_we: got %b%b, required 00", hi_we, lo_we);
        end
        total++;
        if (hi_out !== 32'd0 || lo_out !== 32'd0) begin
            bad++;
            $display("[TB] FAIL reset_out: got hi=%h lo=%h, required 0", hi_out, lo_out);
        end
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        total++;
        if (stallreq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_stall: got %b, required 0", stallreq);
        end
    endtask

    task automatic test_divu;
        int cyc;
        int sl;
        issue(2'b01, 32'd100, 32'd7, 1'b1);
        #1;
        total++;
        if (stallreq !== 1'b1) begin
            bad++;
            $display("[TB] FAIL divu_stall_issue: got %b, required 1", stallreq);
        end
        wait_done(cyc, sl);
        total++;
        if (cyc !== 33) begin
            bad++;
            $display("[TB] FAIL divu_latency: got %0d, required 33", cyc);
        end
        total++;
        if (sl !== 0) begin
            bad++;
            $display("[TB] FAIL divu_stall_run: got %0d low cycles, required 0", sl);
        end
        total++;
        if (lo_out !== 32'd14 || hi_out !== 32'd2) begin
            bad++;
            $display("[TB] FAIL divu_result: got hi=%h lo=%h, required hi=2 lo=e", hi_out, lo_out);
        end
        total++;
        if (stallreq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL done_stall: got %b, required 0", stallreq);
        end
        @(negedge clk);
        total++;
        if (hi_we !== 1'b0) begin
            bad++;
            $display("[TB] FAIL done_one_cycle: got %b, required 0", hi_we);
        end
    endtask

    task automatic test_div;
        int cyc;
        int sl;
        issue(2'b00, 32'hFFFF_FF9C, 32'd7, 1'b1);
        wait_done(cyc, sl);
        total++;
        if (cyc !== 33 || lo_out !== 32'hFFFF_FFF2 || hi_out !== 32'hFFFF_FFFE) begin
            bad++;
            $display("[TB] FAIL div_neg: got cyc=%0d hi=%h lo=%h, required cyc=33 hi=fffffffe lo=fffffff2",
                     cyc, hi_out, lo_out);
        end
        issue(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_done(cyc, sl);
        total++;
        if (lo_out !== 32'h8000_0000 || hi_out !== 32'd0) begin
            bad++;
            $display("[TB] FAIL div_overflow: got hi=%h lo=%h, required hi=0 lo=80000000",
                     hi_out, lo_out);
        end
    endtask

    task automatic test_mult;
        int cyc;
        int sl;
        issue(2'b10, 32'hFFFF_FFFF, 32'd2, 1'b1);
        wait_done(cyc, sl);
        total++;
        if (cyc !== 3 || hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFFE) begin
            bad++;
            $display("[TB] FAIL mult: got cyc=%0d hi=%h lo=%h, required cyc=3 hi=ffffffff lo=fffffffe",
                     cyc, hi_out, lo_out);
        end
        issue(2'b11, 32'hFFFF_FFFF, 32'd2, 1'b1);
        wait_done(cyc, sl);
        total++;
        if (cyc !== 3 || hi_out !== 32'd1 || lo_out !== 32'hFFFF_FFFE) begin
            bad++;
            $display("[TB] FAIL multu: got cyc=%0d hi=%h lo=%h, required cyc=3 hi=1 lo=fffffffe",
                     cyc, hi_out, lo_out);
        end
    endtask

    task automatic test_div_zero;
        int cyc;
        int sl;
        issue(2'b01, 32'h1234, 32'd0, 1'b1);
        wait_done(cyc, sl);
        total++;
        if (cyc !== 1 || lo_out !== 32'hFFFF_FFFF || hi_out !== 32'h1234) begin
            bad++;
            $display("[TB] FAIL divu_zero: got cyc=%0d hi=%h lo=%h, required cyc=1 hi=1234 lo=ffffffff",
                     cyc, hi_out, lo_out);
        end
        issue(2'b00, 32'hF000_0001, 32'd0, 1'b1);
        wait_done(cyc, sl);
        total++;
        if (cyc !== 1 || lo_out !== 32'hFFFF_FFFF || hi_out !== 32'hF000_0001) begin
            bad++;
            $display("[TB] FAIL div_zero: got cyc=%0d hi=%h lo=%h, required cyc=1 hi=f0000001 lo=ffffffff",
                     cyc, hi_out, lo_out);
        end
    endtask

    task automatic test_cancel;
        int cyc;
        int sl;
        int writes;
        issue(2'b00, 32'd1000, 32'd3, 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(negedge clk);
        cancel = 1'b1;
        #1;
        total++;
        if (stallreq !== 1'b0 || hi_we !== 1'b0) begin
            bad++;
            $display("[TB] FAIL cancel_outputs: got stall=%b we=%b, required 0 0", stallreq, hi_we);
        end
        @(negedge clk);
        cancel = 1'b0;
        writes = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (hi_we === 1'b1 || stallreq === 1'b1) writes++;
        end
        total++;
        if (writes !== 0) begin
            bad++;
            $display("[TB] FAIL cancel_idle: got %0d busy/write cycles, required 0", writes);
        end
        // cancel alongside start: nothing may begin
        @(negedge clk);
        start  = 1'b1;
        cancel = 1'b1;
        op     = 2'b01;
        src_a  = 32'd9;
        src_b  = 32'd0;
        #1;
        total++;
        if (stallreq !== 1'b0) begin
            bad++;
            $display("[TB] FAIL cancel_start_stall: got %b, required 0", stallreq);
        end
        @(negedge clk);
        start  = 1'b0;
        cancel = 1'b0;
        repeat (3) @(negedge clk);
        issue(2'b01, 32'hDEAD_BEEF, 32'h1234, 1'b1);
        wait_done(cyc, sl);
        total++;
        if (cyc !== 33) begin
            bad++;
            $display("[TB] FAIL cancel_resume_latency: got %0d, required 33", cyc);
        end
    endtask

    task automatic test_rst_mid;
        issue(2'b00, 32'hFFFF_FF9C, 32'd7, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (stallreq !== 1'b0 || hi_we !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_mid_outputs: got stall=%b we=%b, required 0 0", stallreq, hi_we);
        end
        @(negedge clk);
        total++;
        if (stallreq !== 1'b0 || hi_out !== 32'd0 || lo_out !== 32'd0) begin
            bad++;
            $display("[TB] FAIL rst_mid_state: got stall=%b hi=%h lo=%h, required 0 0 0",
                     stallreq, hi_out, lo_out);
        end
        start = 1'b0;
        rst   = 1'b0;
        repeat (40) @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int          cyc;
        int          sl;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        for (int i = 0; i < 16; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = (i % 5 == 4) ? 32'd0 : $urandom;
            if (i == 3) begin
                o = 2'b10;
                a = 32'h8000_0000;
                b = 32'h8000_0000;
            end
            issue(o, a, b, 1'b1);
            wait_done(cyc, sl);
            total++;
            if (cyc !== latency(o, b) || sl !== 0) begin
                bad++;
                $display("[TB] FAIL b2b_timing: op=%b got cyc=%0d stall_low=%0d, required cyc=%0d stall_low=0",
                         o, cyc, sl, latency(o, b));
            end
        end
        repeat (2) @(negedge clk);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("[TB] FAIL sb_drain: got %0d pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_divu();
        test_div();
        test_mult();
        test_div_zero();
        test_cancel();
        test_rst_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
